sram_bus_master: RTL and testbench
==================================

# sram_bus_master

Clocked initiator for the asynchronous-style SRAM port (addr / addr_ready / read_pulse / write_pulse / datain / dataout). It converts a single-beat valid/ready request from core logic into the SRAM's fixed strobe sequence: address setup, access pulse, hold, release. For reads it captures `dataout` and returns it on a one-cycle response strobe; writes receive the same strobe as an acknowledge. It replaces hand-sequenced stimulus as the SRAM's driver in the core datapath.

## Interface
Parameters:
- ADDR_W, 7, SRAM address width
- DATA_W, 32, SRAM data width
- SETUP_CYC, 1, cycles addr_ready is high before the pulse (≥1)
- PULSE_CYC, 1, cycles read_pulse/write_pulse is high (≥1)
- HOLD_CYC, 1, cycles addr_ready stays high after the pulse (≥1)
- Any of SETUP_CYC/PULSE_CYC/HOLD_CYC = 0 is an elaboration error.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion strobe (reads and writes)
- rsp_rdata  out  DATA_W  read data, valid when rsp_valid && last op was read
- busy  out  1  transaction in progress (state ≠ IDLE)
- addr  out  ADDR_W  to SRAM
- addr_ready  out  1  to SRAM
- read_pulse  out  1  to SRAM
- write_pulse  out  1  to SRAM
- datain  out  DATA_W  to SRAM
- dataout  in  DATA_W  from SRAM

## Operation
- States: IDLE, SETUP, PULSE, HOLD, DONE. One down-counter (width to hold max(SETUP_CYC,PULSE_CYC,HOLD_CYC)-1) times each phase.
- IDLE: req_ready=1. On req_valid && req_ready: latch req_we, req_addr → addr, req_wdata → datain (writes only; datain unchanged on reads); go to SETUP.
- SETUP (SETUP_CYC cycles): addr_ready=1, pulses 0.
- PULSE (PULSE_CYC cycles): addr_ready=1; write_pulse=1 if write else read_pulse=1. Never both.
- HOLD (HOLD_CYC cycles): addr_ready=1, pulses 0. For reads, rsp_rdata ← dataout at the edge ending the last HOLD cycle.
- DONE (1 cycle): addr_ready=0, rsp_valid=1; → IDLE.
- addr and datain stay stable from the accept edge until the next accept; they never change while addr_ready=1.
- rsp_rdata holds its value until the next read capture; unchanged by writes.
- req_valid in any state other than IDLE is ignored (req_ready=0); no queuing.
- All SRAM-side outputs and req_ready/rsp_valid/busy are registered or decoded from registered state only; no combinational path from req_* to SRAM outputs.

## Timing
- Reset: while rst high at an edge → state IDLE, counter 0, addr=0, datain=0, rsp_rdata=0, addr_ready=0, read_pulse=0, write_pulse=0, rsp_valid=0. req_ready=0 and busy=0 during any cycle in which rst is high; requests ignored.
- Reset mid-transaction: abort; in the cycle after the reset edge all SRAM strobes are 0 and no rsp_valid is issued. A write aborted during PULSE may have partially completed at the SRAM; this is accepted behaviour.
- Latency (accept edge = E0): addr_ready high cycles E0+1 … E0+SETUP+PULSE+HOLD; pulse high cycles E0+SETUP+1 … E0+SETUP+PULSE; rsp_valid in cycle E0+SETUP+PULSE+HOLD+1; req_ready=1 again the following cycle.
- Defaults: SETUP cycle 1, PULSE cycle 2, HOLD cycle 3, DONE cycle 4, IDLE cycle 5 → one transaction per 5 cycles, back-to-back.
- Response is exactly one cycle; no backpressure on rsp.

## Test plan
- Write 0x0000_0555 to addr 11 (defaults) → addr=11 and datain=0x555 from E0+1; addr_ready high cycles 1–3, write_pulse high cycle 2 only, rsp_valid cycle 4, read_pulse never high.
- Read addr 11 after that write (SRAM model) → read_pulse high cycle 2 only; rsp_valid cycle 4 with rsp_rdata=0x0000_0555; datain unchanged.
- Back-to-back: req_valid held high with 128 sequential reads addr 0..127 → accepts every 5th cycle, 128 rsp_valid pulses, rsp_rdata matches preload, addr wraps 127→0 on next request.
- Stretched timing SETUP=2, PULSE=3, HOLD=2, read → addr_ready high cycles 1–7, read_pulse high cycles 3–5, rsp_valid cycle 8.
- rst asserted during PULSE of a write → next cycle addr_ready=write_pulse=rsp_valid=0, addr=0, state IDLE; req_ready=1 the cycle after rst drops.
- req_valid toggled and req_addr changed while busy → ignored; addr and datain stable throughout addr_ready high.

Source files
------------

// File: rtl/sram_bus_master.sv
// SRAM port initiator: turns one valid/ready request into the setup/pulse/hold
// strobe sequence and returns a one-cycle response strobe with captured read data.
module sram_bus_master #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_ready,
  output logic              read_pulse,
  output logic              write_pulse,
  output logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // SETUP | address driven, addr_ready high, no pulse yet
  // PULSE | read_pulse or write_pulse high
  // HOLD  | address held after the pulse; read data captured on last cycle
  // DONE  | one-cycle response strobe
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
    $error("sram_bus_master: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr      <= '0;
      datain    <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            addr  <= req_addr;
            if (req_we) datain <= req_wdata;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= PULSE_LD;
            state <= PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            // dataout has been settled for the whole hold window by now
            if (!we_q) rsp_rdata <= dataout;
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign addr_ready  = (state == SETUP) || (state == PULSE) || (state == HOLD);
  assign read_pulse  = (state == PULSE) && !we_q;
  assign write_pulse = (state == PULSE) && we_q;
  assign rsp_valid   = (state == DONE);
  assign req_ready   = !rst && (state == IDLE);
  assign busy        = !rst && (state != IDLE);

endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master: default-timing instance on an SRAM model plus a
// stretched-timing instance; read responses are checked against a scoreboard.
module tb_sram_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [6:0]  addr;
  logic        addr_ready;
  logic        read_pulse;
  logic        write_pulse;
  logic [31:0] datain;
  logic [31:0] dataout;

  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic        s_req_we = 1'b0;
  logic [6:0]  s_req_addr = '0;
  logic [31:0] s_req_wdata = '0;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_rdata;
  logic        s_busy;
  logic [6:0]  s_addr;
  logic        s_addr_ready;
  logic        s_read_pulse;
  logic        s_write_pulse;
  logic [31:0] s_datain;
  logic [31:0] s_dataout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_count = 0;

  typedef struct {
    logic        we;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] sram [0:127];
  logic [31:0] ref_mem [0:127];
  logic [31:0] last_din = '0;
  bit          preload = 1'b1;

  sram_bus_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .addr(addr),
    .addr_ready(addr_ready), .read_pulse(read_pulse), .write_pulse(write_pulse),
    .datain(datain), .dataout(dataout)
  );

  sram_bus_master #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) dut_s (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_we(s_req_we), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .busy(s_busy), .addr(s_addr),
    .addr_ready(s_addr_ready), .read_pulse(s_read_pulse), .write_pulse(s_write_pulse),
    .datain(s_datain), .dataout(s_dataout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h0001_0203);
  endfunction

  // SRAM model shared by both instances; only the default instance writes
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) sram[i] <= init_val(i);
    end else if (write_pulse) begin
      sram[addr] <= datain;
    end
  end
  assign dataout   = sram[addr];
  assign s_dataout = sram[s_addr];

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected at cycle %0d got rsp_valid=1 exp 0", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        rsp_count++;
        if (!e.we) begin
          checks++;
          if (rsp_rdata !== e.data) begin
            errors++;
            $display("FAIL rsp_rdata got %h exp %h", rsp_rdata, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, busy, addr_ready, read_pulse, write_pulse, rsp_valid} !== 6'b0 ||
        addr !== 7'd0 || datain !== 32'd0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got rr=%b busy=%b ar=%b rp=%b wp=%b rv=%b addr=%h din=%h rd=%h exp all zero",
               req_ready, busy, addr_ready, read_pulse, write_pulse, rsp_valid, addr, datain, rsp_rdata);
    end
    preload = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got req_ready=%b busy=%b exp 1 0", req_ready, busy);
    end
  endtask

  // One default-timing transaction; called while idle, returns idle.
  task automatic run_txn(input logic we, input logic [6:0] a, input logic [31:0] d, input bit noise);
    logic [5:0]  obs, expv;
    logic [31:0] exp_din;
    exp_din = we ? d : last_din;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb_q.push_back('{we: we, data: (we ? d : ref_mem[a])});
    if (we) ref_mem[a] = d;
    last_din = exp_din;
    for (int c = 1; c <= 5; c++) begin
      obs  = {addr_ready, read_pulse, write_pulse, rsp_valid, req_ready, busy};
      expv = {c <= 3, !we && c == 2, we && c == 2, c == 4, c == 5, c <= 4};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL strobes we=%b cycle %0d got ar,rp,wp,rv,rr,busy=%b exp %b", we, c, obs, expv);
      end
      checks++;
      if (addr !== a || datain !== exp_din) begin
        errors++;
        $display("FAIL addr_datain cycle %0d got addr=%h din=%h exp addr=%h din=%h", c, addr, datain, a, exp_din);
      end
      if (noise && c <= 3) begin
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 7'($urandom);
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write();
    run_txn(1'b1, 7'd11, 32'h0000_0555, 1'b0);
  endtask

  task automatic test_read();
    run_txn(1'b0, 7'd11, 32'hFFFF_0000, 1'b0);
  endtask

  task automatic test_ignore_while_busy();
    run_txn(1'b1, 7'd60, 32'hDEAD_BEEF, 1'b1);
    run_txn(1'b0, 7'd60, 32'h0, 1'b1);
  endtask

  task automatic test_stretched();
    logic [3:0] obs, expv;
    s_req_we = 1'b0; s_req_addr = 7'd20; s_req_valid = 1'b1;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      obs  = {s_addr_ready, s_read_pulse | s_write_pulse, s_rsp_valid, s_req_ready};
      expv = {c <= 7, c >= 3 && c <= 5, c == 8, c == 9};
      checks++;
      if (obs !== expv || s_write_pulse !== 1'b0) begin
        errors++;
        $display("FAIL stretched cycle %0d got ar,pulse,rv,rr=%b wp=%b exp %b wp=0", c, obs, s_write_pulse, expv);
      end
      if (c == 8) begin
        checks++;
        if (s_rsp_rdata !== ref_mem[20]) begin
          errors++;
          $display("FAIL stretched_rdata got %h exp %h", s_rsp_rdata, ref_mem[20]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int  prev, waited, base;
    bit  was;
    base = rsp_count;
    prev = 0;
    req_we = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i <= 128; i++) begin
      req_addr = 7'(i);
      waited = 0; was = 1'b0;
      while (!was && waited < 20) begin
        was = req_ready;
        @(posedge clk); #1;
        waited++;
      end
      if (!was) begin
        checks++; errors++;
        $display("FAIL b2b_accept_timeout req %0d got no accept exp accept within 20 cycles", i);
        break;
      end
      sb_q.push_back('{we: 1'b0, data: ref_mem[i % 128]});
      checks++;
      if (addr !== 7'(i)) begin
        errors++;
        $display("FAIL b2b_addr req %0d got %h exp %h", i, addr, 7'(i));
      end
      if (i > 0) begin
        checks++;
        if (cyc - prev != 5) begin
          errors++;
          $display("FAIL b2b_spacing req %0d got %0d exp 5", i, cyc - prev);
        end
      end
      prev = cyc;
    end
    req_valid = 1'b0;
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (rsp_count - base != 129) begin
      errors++;
      $display("FAIL b2b_rsp_count got %0d exp 129", rsp_count - base);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [5:0] obs;
    req_we = 1'b1; req_addr = 7'd40; req_wdata = 32'h0000_1234; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (write_pulse !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_pulse got write_pulse=%b exp 1", write_pulse);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    obs = {addr_ready, write_pulse, read_pulse, rsp_valid, req_ready, busy};
    checks++;
    if (obs !== 6'b0 || addr !== 7'd0) begin
      errors++;
      $display("FAIL midrst_abort got ar,wp,rp,rv,rr,busy=%b addr=%h exp 000000 addr=00", obs, addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_recover got rr=%b busy=%b rv=%b exp 1 0 0", req_ready, busy, rsp_valid);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_write();
    test_read();
    test_ignore_while_busy();
    test_stretched();
    test_back_to_back();
    test_reset_mid_write();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
